// File: rtl/cache_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package : cache_pkg
// Brief   : Shared widths, FSM encoding and address helpers for the tag
//           controller of a direct-mapped 128-line, 16-byte-line cache.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
package cache_pkg;

  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 4;
  localparam int INDEX_W  = 7;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int ENTRY_W  = TAG_W + 1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Line index of a byte address (bits just above the line offset)
  function automatic logic [INDEX_W-1:0] index_of(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  // Tag of a byte address (everything above the index)
  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/tag_sweep_cnt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tag_sweep_cnt
// Brief   : Index counter for the tag-clear sweep. Synchronous clear has
//           priority over enable; 'last' flags the final enabled count.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tag_sweep_cnt
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  output logic [INDEX_W-1:0] cnt,
  output logic               last
);

  // Count up through every tag entry; clear returns to entry 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = en & (cnt == {INDEX_W{1'b1}});

endmodule
`default_nettype wire

// File: rtl/cache_tag_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : cache_tag_ctrl
// Brief   : Tag-array controller. Clears all tags after reset, then serves
//           two-stage tag lookups (address in stage 1, hit/miss in stage 2)
//           and line-fill tag writes, fills taking priority over lookups.
//           Optional feature macro: CACHE_TAG_FLUSH_EN adds a 'flush' input
//           that re-runs the clear sweep.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module cache_tag_ctrl
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               rsp_valid,
  output logic               rsp_hit,
  input  logic               fill_valid,
  output logic               fill_ready,
  input  logic [ADDR_W-1:0]  fill_addr,
`ifdef CACHE_TAG_FLUSH_EN
  input  logic               flush,
`endif
  output logic               init_done,
  output logic [INDEX_W-1:0] sram_addr,
  output logic               sram_wen,
  output logic [ENTRY_W-1:0] sram_din,
  input  logic [ENTRY_W-1:0] sram_dout
);

  state_t             state;
  state_t             state_nxt;
  logic [INDEX_W-1:0] cnt;
  logic               cnt_last;
  logic               cnt_clr;
  logic               cnt_en;
  logic               flush_req;
  logic               fill_acc;
  logic               req_acc;
  logic [TAG_W-1:0]   req_tag_q;
  logic [INDEX_W-1:0] addr_hold;
  logic               unused_offset;

`ifdef CACHE_TAG_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // Line-offset bits never reach the tag array
  assign unused_offset = ^{req_addr[OFFSET_W-1:0], fill_addr[OFFSET_W-1:0]};

  // Counter is held at zero outside the sweep so every sweep starts at entry 0
  assign cnt_clr = (state == ST_RUN) | flush_req;
  assign cnt_en  = (state == ST_INIT);

  tag_sweep_cnt u_sweep (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .cnt  (cnt),
    .last (cnt_last)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: sweep until the last entry is written, flush re-enters sweep
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: begin
        if (!flush_req && cnt_last) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush_req) begin
          state_nxt = ST_INIT;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign init_done  = (state == ST_RUN);
  assign fill_ready = init_done;
  assign req_ready  = init_done & ~fill_valid;
  assign fill_acc   = fill_valid & init_done;
  assign req_acc    = req_valid & req_ready;

  // Stage 1 SRAM drive: sweep write, else fill write, else lookup read, else hold
  always_comb begin
    sram_addr = addr_hold;
    sram_wen  = 1'b1;
    sram_din  = '0;
    if (!rst) begin
      if (state == ST_INIT) begin
        sram_addr = cnt;
        sram_wen  = 1'b0;
      end else if (fill_acc) begin
        sram_addr = index_of(fill_addr);
        sram_wen  = 1'b0;
        sram_din  = {1'b1, tag_of(fill_addr)};
      end else if (req_acc) begin
        sram_addr = index_of(req_addr);
      end
    end
  end

  // Remember the last driven address so idle cycles keep the SRAM address stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_hold <= '0;
    end else begin
      addr_hold <= sram_addr;
    end
  end

  // Stage 2 bookkeeping: response strobe and the tag to compare against
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      req_tag_q <= '0;
    end else begin
      rsp_valid <= req_acc;
      if (req_acc) begin
        req_tag_q <= tag_of(req_addr);
      end
    end
  end

  // Hit is resolved straight off the SRAM read data in the response cycle
  assign rsp_hit = rsp_valid & sram_dout[ENTRY_W-1] &
                   (sram_dout[TAG_W-1:0] == req_tag_q);

endmodule
`default_nettype wire
